des_perm_pipe: RTL
==================

// Module: des_perm_pipe
// PURPOSE
//  Pipelined DES bit-permutation engine. Applies IP or FP (IP^-1) to a 64-bit block.
//  Mode is selectable per transaction; an optional per-transaction half-swap forms R16||L16.
//  Valid/ready handshake with full backpressure; sustains 1 block/cycle.
//  Sits between the block I/O interface and the round datapath: IP on entry, FP on exit.
// PARAMETERS
//  STAGES  2  register stages, legal 1..4; latency in cycles from accept to out_valid
//  TAG_W   4  width of the sideband tag carried alongside each block (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input block present
//  in_ready   out  1      engine accepts; transfer occurs when in_valid & in_ready
//  in_mode    in   1      0 = IP, 1 = FP
//  in_swap    in   1      1 = permute {in_data[31:0],in_data[63:32]} instead of in_data
//  in_data    in   64     block; DES bit 1 = in_data[63]
//  in_tag     in   TAG_W  sideband, returned unchanged with the result
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  out_data   out  64     permuted block; DES bit 1 = out_data[63]
//  out_tag    out  TAG_W  tag of the result
//  busy       out  1      OR of all stage valid bits
// BEHAVIOUR
//  - Bit rule (MSB-first DES numbering): out bit k = src bit T[k], k=1..64.
//    T = IP: 58 50 42 34 26 18 10 2, 60 52 ... 4, 62 ... 6, 64 ... 8, 57 49 ... 1, 59 ... 3, 61 ... 5, 63 ... 7.
//    T = FP: 40 8 48 16 56 24 64 32, 39 7 47 15 55 23 63 31, ..., 33 1 41 9 49 17 57 25.
//    src = in_swap ? {in_data[31:0],in_data[63:32]} : in_data. FP(IP(x)) == x for every x.
//  - Swap and permutation are combinational ahead of stage 0; stage 0 captures the result, tag and valid.
//    Stages 1..STAGES-1 are pure delay. out_* are driven directly from the last stage.
//  - Stage s loads when it is empty or its contents leave this cycle:
//    adv[last] = ~v[last] | out_ready;  adv[s] = ~v[s] | (v[s+1]==0) | adv[s+1].
//    Loading stage s sets v[s] = v[s-1] (or in_valid for s=0); data and tag move with it.
//  - in_ready = adv[0], combinational from out_ready, with no path from in_valid.
//  - Latency: a block accepted in cycle N gives out_valid in cycle N+STAGES when no stall occurs.
//  - Throughput: back-to-back accepts while out_ready=1; no bubbles inserted.
//  - Backpressure: with out_ready=0 the pipe fills. After STAGES accepts, in_ready=0.
//    out_data/out_tag stay stable while out_valid & ~out_ready.
//  - Blocks never reorder, duplicate or drop. Mode, swap and tag are sampled per block at acceptance.
//  - Reset: all v[] = 0; out_valid=0, out_data=0, out_tag=0, busy=0. in_ready=1 in the first cycle after reset.
//    Reset asserted mid-operation discards all in-flight blocks; no partial output appears.
//  - in_data change while in_valid & ~in_ready: the engine ignores it; the value at the accepting edge is used.
// TESTING
//  1 IP KAT: mode=0, swap=0, data=0123456789ABCDEF -> out=CC00CCFFF0AAF0AA, after STAGES cycles, tag echoed.
//  2 FP KAT with swap: mode=1, swap=1, data=434232340A4CD995 -> out=85E813540F0AB405.
//  3 Round trip: 1000 random x with IP then FP, mode alternating per cycle, out_ready=1 -> FP(IP(x))==x.
//    One result per cycle, order preserved.
//  4 Backpressure: out_ready=0 and 6 blocks offered -> exactly STAGES accepted, then in_ready=0 and out_data held.
//    Then out_ready=1 -> all 6 emerge in order, tags 0..5.
//  5 Random out_ready toggling (50%) plus random in_valid, 5000 blocks -> scoreboard matches and none lost.
//  6 Reset with a full pipe -> next cycle out_valid=0, busy=0, in_ready=1, and no stale block appears afterwards.

Source files
------------

// File: rtl/des_perm_pipe.sv
// ---------------------------------------------------------------------------
// des_perm_pipe
//
// Pipelined DES bit-permutation engine.  Each accepted block is optionally
// half-swapped (R||L), then run through either the initial permutation (IP)
// or its inverse (FP).  The result is carried through STAGES register stages
// together with a sideband tag.  Valid/ready on both sides with full
// backpressure; one block per cycle when the consumer keeps out_ready high.
//
// Parameters
//   STAGES    number of register stages (1..4), equals accept-to-output latency
//   TAG_W     width of the sideband tag
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input block present
//   in_ready   engine can take a block this cycle
//   in_mode    0 = IP, 1 = FP
//   in_swap    1 = permute {in_data[31:0], in_data[63:32]}
//   in_data    64-bit block, DES bit 1 = in_data[63]
//   in_tag     sideband tag, returned with the result
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   out_data   permuted block, DES bit 1 = out_data[63]
//   out_tag    tag belonging to out_data
//   busy       any stage holds a block
// ---------------------------------------------------------------------------
module des_perm_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic             in_swap,
    input  logic [63:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // IP table generated row by row: rows 0..3 take the even source bits
    // 2,4,6,8 as their lowest entry, rows 4..7 the odd bits 1,3,5,7, and each
    // row walks upward in steps of 8 from right to left.
    function automatic logic [63:0] permute_ip(input logic [63:0] src);
        logic [63:0] res;
        int          sel;
        res = '0;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                sel = 8 * (7 - col) + ((row < 4) ? 2 * (row + 1) : 2 * (row - 4) + 1);
                res[63 - (8 * row + col)] = src[64 - sel];
            end
        end
        return res;
    endfunction

    // FP table: even columns start at 40-row, odd columns at 8-row, and
    // every column pair steps up by 8.
    function automatic logic [63:0] permute_fp(input logic [63:0] src);
        logic [63:0] res;
        int          sel;
        res = '0;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                sel = (((col % 2) == 0) ? 40 : 8) - row + 8 * (col / 2);
                res[63 - (8 * row + col)] = src[64 - sel];
            end
        end
        return res;
    endfunction

    logic [63:0]      src_data;
    logic [63:0]      perm_data;

    logic [STAGES-1:0] v;
    logic [63:0]       d [STAGES];
    logic [TAG_W-1:0]  t [STAGES];
    logic [STAGES-1:0] adv;
    logic              all_full;

    assign src_data  = in_swap ? {in_data[31:0], in_data[63:32]} : in_data;
    assign perm_data = in_mode ? permute_fp(src_data) : permute_ip(src_data);

    // Unrolled form of adv[s] = ~v[s] | ~v[s+1] | adv[s+1]: stage s may load
    // whenever out_ready is high or any stage from s to the end is empty.
    // Writing it as a running AND avoids a self-referencing vector.
    always_comb begin
        adv      = '0;
        all_full = 1'b1;
        for (int s = STAGES - 1; s >= 0; s--) begin
            all_full = all_full & v[s];
            adv[s]   = out_ready | ~all_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int s = 0; s < STAGES; s++) begin
                d[s] <= '0;
                t[s] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                d[0] <= perm_data;
                t[0] <= in_tag;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (adv[s]) begin
                    v[s] <= v[s-1];
                    d[s] <= d[s-1];
                    t[s] <= t[s-1];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
    assign out_tag   = t[STAGES-1];
    assign busy      = |v;

endmodule
